// File: rtl/reg_bank_x86_pkg.sv
// rtl/reg_bank_x86_pkg.sv - selector encoding, register indices and decode helpers for the x86 register bank
package reg_bank_x86_pkg;

  typedef enum logic [3:0] {
    SEL_AL = 4'd0,  SEL_CL = 4'd1,  SEL_DL = 4'd2,  SEL_BL = 4'd3,
    SEL_AH = 4'd4,  SEL_CH = 4'd5,  SEL_DH = 4'd6,  SEL_BH = 4'd7,
    SEL_AX = 4'd8,  SEL_CX = 4'd9,  SEL_DX = 4'd10, SEL_BX = 4'd11,
    SEL_SP = 4'd12, SEL_BP = 4'd13, SEL_SI = 4'd14, SEL_DI = 4'd15
  } sel_e;

  localparam logic [2:0] IDX_AX = 3'd0;
  localparam logic [2:0] IDX_CX = 3'd1;
  localparam logic [2:0] IDX_DX = 3'd2;
  localparam logic [2:0] IDX_BX = 3'd3;
  localparam logic [2:0] IDX_SP = 3'd4;
  localparam logic [2:0] IDX_BP = 3'd5;
  localparam logic [2:0] IDX_SI = 3'd6;
  localparam logic [2:0] IDX_DI = 3'd7;

  function automatic logic is_byte_sel(input logic [3:0] sel);
    return !sel[3];
  endfunction

  function automatic logic is_high_byte(input logic [3:0] sel);
    return (sel[3:2] == 2'b01);
  endfunction

  // Byte and word selectors 0-11 all map onto AX..BX; only 12-15 reach SP..DI.
  function automatic logic [2:0] sel_to_idx(input logic [3:0] sel);
    return {sel[3] & sel[2], sel[1:0]};
  endfunction

endpackage

// File: rtl/reg_bank_x86_rport.sv
// rtl/reg_bank_x86_rport.sv - one registered read port with byte-lane extraction
module reg_bank_x86_rport
  import reg_bank_x86_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_regs [NUM_BANKS][8],
  input  logic              i_rd,
  input  logic [3:0]        i_rsel,
  input  logic [BANK_W-1:0] i_bank,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid
);

  logic [BANK_W-1:0] w_bank;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  always_comb begin
    w_bank  = (int'(i_bank) < NUM_BANKS) ? i_bank : '0;
    w_word  = i_regs[w_bank][sel_to_idx(i_rsel)];
    w_rdata = '0;
    if (!is_byte_sel(i_rsel)) begin
      w_rdata = w_word;
    end else if (is_high_byte(i_rsel)) begin
      w_rdata[15:8] = w_word[15:8];
    end else begin
      w_rdata[7:0] = w_word[7:0];
    end
  end

  // Data holds while idle so downstream can keep sampling the last result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_rd;
      if (i_rd) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

endmodule

// File: rtl/reg_bank_x86_mp.sv
// rtl/reg_bank_x86_mp.sv - multi-bank x86 register file with SP stepping and write-first read bypass
module reg_bank_x86_mp
  import reg_bank_x86_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                NUM_BANKS = 2,
  parameter logic [DATA_W-1:0] SP_RESET  = 'hFFFE,
  localparam int               BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BANK_W-1:0] i_bank,
  input  logic              i_wr,
  input  logic [3:0]        i_wsel,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_sp_push,
  input  logic              i_sp_pop,
  input  logic              i_rd_a,
  input  logic [3:0]        i_rsel_a,
  input  logic              i_rd_b,
  input  logic [3:0]        i_rsel_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_rvalid_a,
  output logic              o_rvalid_b,
  output logic              o_conflict
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(DATA_W / 8);

  logic [DATA_W-1:0] r_regs [NUM_BANKS][8];
  logic [DATA_W-1:0] w_next [NUM_BANKS][8];
  logic [BANK_W-1:0] w_bank;
  logic [2:0]        w_widx;
  logic [DATA_W-1:0] w_merged;
  logic              w_sp_wr;
  logic              w_step;
  logic              w_conflict;
  logic              r_conflict;

  always_comb begin
    w_bank   = (int'(i_bank) < NUM_BANKS) ? i_bank : '0;
    w_widx   = sel_to_idx(i_wsel);
    w_merged = r_regs[w_bank][w_widx];
    if (!is_byte_sel(i_wsel)) begin
      w_merged = i_wdata;
    end else if (is_high_byte(i_wsel)) begin
      w_merged[15:8] = i_wdata[15:8];
    end else begin
      w_merged[7:0] = i_wdata[7:0];
    end

    // An explicit SP write overrides a single step; push+pop cancel without a conflict.
    w_sp_wr    = i_wr && (i_wsel == SEL_SP);
    w_step     = (i_sp_push ^ i_sp_pop) && !w_sp_wr;
    w_conflict = w_sp_wr && (i_sp_push ^ i_sp_pop);

    w_next = r_regs;
    if (i_wr) begin
      w_next[w_bank][w_widx] = w_merged;
    end
    if (w_step) begin
      w_next[w_bank][IDX_SP] = i_sp_push ? (r_regs[w_bank][IDX_SP] - STEP)
                                         : (r_regs[w_bank][IDX_SP] + STEP);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int r = 0; r < 8; r++) begin
          r_regs[b][r] <= (r == int'(IDX_SP)) ? SP_RESET : '0;
        end
      end
      r_conflict <= 1'b0;
    end else begin
      r_regs     <= w_next;
      r_conflict <= w_conflict;
    end
  end

  assign o_conflict = r_conflict;

  // Both ports look at the post-update array, giving write-first bypass.
  reg_bank_x86_rport #(
    .DATA_W   (DATA_W),
    .NUM_BANKS(NUM_BANKS),
    .BANK_W   (BANK_W)
  ) u_rport_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_regs  (w_next),
    .i_rd    (i_rd_a),
    .i_rsel  (i_rsel_a),
    .i_bank  (i_bank),
    .o_rdata (o_rdata_a),
    .o_rvalid(o_rvalid_a)
  );

  reg_bank_x86_rport #(
    .DATA_W   (DATA_W),
    .NUM_BANKS(NUM_BANKS),
    .BANK_W   (BANK_W)
  ) u_rport_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_regs  (w_next),
    .i_rd    (i_rd_b),
    .i_rsel  (i_rsel_b),
    .i_bank  (i_bank),
    .o_rdata (o_rdata_b),
    .o_rvalid(o_rvalid_b)
  );

endmodule
